// File: rtl/db_beta_arb.sv
// -----------------------------------------------------------------------------
// db_beta_arb
//   Shares one deblocking beta ROM (6-bit indexB -> 5-bit beta) between the
//   luma and chroma edge filters. Each accepted request gets
//     indexB = Clip3(0, 51, ((qp_p + qp_q + 1) >> 1) + offset_b)
//   and the ROM result is returned in order with its source and tag.
//   The datapath has two stages: S1 holds indexB and drives the ROM address,
//   and S2 registers the ROM output.
//
// Configuration macro:
//   DB_BETA_LUMA_PRIO_EN  defined   -> fixed priority, luma always wins ties
//                         undefined -> round-robin between luma and chroma
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   offset_b_i               signed FilterOffsetB, sampled when a request is accepted
//   lu_req_i/lu_qp_p_i/lu_qp_q_i/lu_tag_i/lu_ack_o   luma request channel
//   ch_req_i/ch_qp_p_i/ch_qp_q_i/ch_tag_i/ch_ack_o   chroma request channel
//   rom_addr_o, rom_q_i      external beta ROM (combinational read)
//   beta_vld_o/beta_o/beta_src_o/beta_tag_o/beta_rdy_i  result channel
//                            (beta_src_o: 0 = luma, 1 = chroma)
// -----------------------------------------------------------------------------
module db_beta_arb #(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [4:0] offset_b_i,
  input  logic              lu_req_i,
  input  logic [5:0]        lu_qp_p_i,
  input  logic [5:0]        lu_qp_q_i,
  input  logic [TAG_W-1:0]  lu_tag_i,
  output logic              lu_ack_o,
  input  logic              ch_req_i,
  input  logic [5:0]        ch_qp_p_i,
  input  logic [5:0]        ch_qp_q_i,
  input  logic [TAG_W-1:0]  ch_tag_i,
  output logic              ch_ack_o,
  output logic [5:0]        rom_addr_o,
  input  logic [4:0]        rom_q_i,
  output logic              beta_vld_o,
  output logic [4:0]        beta_o,
  output logic              beta_src_o,
  output logic [TAG_W-1:0]  beta_tag_o,
  input  logic              beta_rdy_i
);

  localparam logic [5:0] QP_MAX = 6'd51;

  // Out-of-range qp (52..63) is treated as the maximum legal value.
  function automatic logic [5:0] clamp_qp(input logic [5:0] qp);
    return (qp > QP_MAX) ? QP_MAX : qp;
  endfunction

  // indexB = Clip3(0, 51, avg(qp_p, qp_q) + offset). The offset add is done
  // in a signed 8-bit intermediate so a negative result is visible for clipping.
  function automatic logic [5:0] calc_idx(input logic [5:0]        qp_p,
                                          input logic [5:0]        qp_q,
                                          input logic signed [4:0] off);
    logic [6:0]        sum;
    logic signed [7:0] idx_s;
    sum   = {1'b0, clamp_qp(qp_p)} + {1'b0, clamp_qp(qp_q)} + 7'd1;
    idx_s = signed'({2'b00, sum[6:1]}) + signed'({{3{off[4]}}, off});
    if (idx_s < 8'sd0)
      return 6'd0;
    else if (idx_s > 8'sd51)
      return QP_MAX;
    else
      return idx_s[5:0];
  endfunction

  logic             ld1, ld2, xfer;
  logic             grant_lu, grant_ch;
  logic             vld_p1;
  logic [5:0]       idx_p1;
  logic             src_p1;
  logic [TAG_W-1:0] tag_p1;
  logic             vld_p2;
  logic [4:0]       beta_p2;
  logic             src_p2;
  logic [TAG_W-1:0] tag_p2;

  assign ld2 = ~vld_p2 | beta_rdy_i;
  assign ld1 = ~vld_p1 | ld2;

`ifdef DB_BETA_LUMA_PRIO_EN
  assign grant_lu = lu_req_i;
  assign grant_ch = ch_req_i & ~lu_req_i;
`else
  // last_ch = 1 means chroma was granted most recently, so luma wins the next tie.
  logic last_ch;

  assign grant_lu = lu_req_i & (~ch_req_i | last_ch);
  assign grant_ch = ch_req_i & (~lu_req_i | ~last_ch);

  always_ff @(posedge clk) begin
    if (rst)
      last_ch <= 1'b1;
    else if (xfer)
      last_ch <= grant_ch;
  end
`endif

  // Acks are suppressed during reset so nothing is handed over on a reset edge.
  assign lu_ack_o = grant_lu & ld1 & ~rst;
  assign ch_ack_o = grant_ch & ld1 & ~rst;
  assign xfer     = lu_ack_o | ch_ack_o;

  // ---- Stage 1: indexB computation, drives ROM address ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      idx_p1 <= 6'd0;
      src_p1 <= 1'b0;
      tag_p1 <= '0;
    end else if (ld1) begin
      vld_p1 <= xfer;
      if (xfer) begin
        src_p1 <= ch_ack_o;
        if (ch_ack_o) begin
          idx_p1 <= calc_idx(ch_qp_p_i, ch_qp_q_i, offset_b_i);
          tag_p1 <= ch_tag_i;
        end else begin
          idx_p1 <= calc_idx(lu_qp_p_i, lu_qp_q_i, offset_b_i);
          tag_p1 <= lu_tag_i;
        end
      end
    end
  end

  assign rom_addr_o = idx_p1;

  // ---- Stage 2: registered ROM output ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      beta_p2 <= 5'd0;
      src_p2  <= 1'b0;
      tag_p2  <= '0;
    end else if (ld2) begin
      vld_p2  <= vld_p1;
      beta_p2 <= rom_q_i;
      src_p2  <= src_p1;
      tag_p2  <= tag_p1;
    end
  end

  assign beta_vld_o = vld_p2;
  assign beta_o     = beta_p2;
  assign beta_src_o = src_p2;
  assign beta_tag_o = tag_p2;

endmodule

// File: tb/tb_db_beta_arb.sv
// -----------------------------------------------------------------------------
// tb_db_beta_arb
//   Directed testbench for db_beta_arb. A behavioural beta ROM table is
//   attached to the ROM port; expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_db_beta_arb;
  localparam int TAG_W = 4;

  // beta for indexB 16..51 (indexB 0..15 gives 0)
  localparam int BTAB [36] = '{2,2,2,3,3,3,3,4,4,4,6,6,7,7,8,8,9,9,10,10,
                               11,11,12,12,13,13,14,14,15,15,16,16,17,17,18,18};

  logic              clk = 1'b0;
  logic              rst;
  logic signed [4:0] offset_b_i;
  logic              lu_req_i;
  logic [5:0]        lu_qp_p_i, lu_qp_q_i;
  logic [TAG_W-1:0]  lu_tag_i;
  logic              lu_ack_o;
  logic              ch_req_i;
  logic [5:0]        ch_qp_p_i, ch_qp_q_i;
  logic [TAG_W-1:0]  ch_tag_i;
  logic              ch_ack_o;
  logic [5:0]        rom_addr_o;
  logic [4:0]        rom_q_i;
  logic              beta_vld_o;
  logic [4:0]        beta_o;
  logic              beta_src_o;
  logic [TAG_W-1:0]  beta_tag_o;
  logic              beta_rdy_i;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [4:0] beta_lut(input logic [5:0] idx);
    if (idx < 6'd16 || idx > 6'd51)
      return 5'd0;
    return 5'(BTAB[int'(idx) - 16]);
  endfunction

  assign rom_q_i = beta_lut(rom_addr_o);

  always #5 clk = ~clk;

  db_beta_arb #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .offset_b_i (offset_b_i),
    .lu_req_i   (lu_req_i),
    .lu_qp_p_i  (lu_qp_p_i),
    .lu_qp_q_i  (lu_qp_q_i),
    .lu_tag_i   (lu_tag_i),
    .lu_ack_o   (lu_ack_o),
    .ch_req_i   (ch_req_i),
    .ch_qp_p_i  (ch_qp_p_i),
    .ch_qp_q_i  (ch_qp_q_i),
    .ch_tag_i   (ch_tag_i),
    .ch_ack_o   (ch_ack_o),
    .rom_addr_o (rom_addr_o),
    .rom_q_i    (rom_q_i),
    .beta_vld_o (beta_vld_o),
    .beta_o     (beta_o),
    .beta_src_o (beta_src_o),
    .beta_tag_o (beta_tag_o),
    .beta_rdy_i (beta_rdy_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated request; checks ack, S1 address and the S2 result.
  task automatic single(input bit is_ch, input logic [5:0] p, input logic [5:0] q,
                        input logic signed [4:0] off, input logic [TAG_W-1:0] tag,
                        input logic [5:0] exp_idx, input logic [4:0] exp_beta,
                        input string nm);
    step();
    offset_b_i = off;
    if (is_ch) begin
      ch_req_i = 1'b1; ch_qp_p_i = p; ch_qp_q_i = q; ch_tag_i = tag;
    end else begin
      lu_req_i = 1'b1; lu_qp_p_i = p; lu_qp_q_i = q; lu_tag_i = tag;
    end
    #1;
    check({nm, "_ack"}, is_ch ? ch_ack_o : lu_ack_o, 1);
    step();
    lu_req_i = 1'b0;
    ch_req_i = 1'b0;
    #1;
    check({nm, "_idx"}, rom_addr_o, exp_idx);
    check({nm, "_vld_n1"}, beta_vld_o, 0);
    step();
    check({nm, "_vld"}, beta_vld_o, 1);
    check({nm, "_beta"}, beta_o, exp_beta);
    check({nm, "_src"}, beta_src_o, is_ch);
    check({nm, "_tag"}, beta_tag_o, tag);
  endtask

  initial begin
    int sent;
    int got;
    bit exp_l;
    bit exp_src;
    bit stall_ack [10] = '{1,1,1,0,0,0,1,0,0,0};

    rst = 1'b1;
    offset_b_i = 5'sd0;
    lu_req_i = 1'b1; lu_qp_p_i = 6'd28; lu_qp_q_i = 6'd29; lu_tag_i = '0;
    ch_req_i = 1'b0; ch_qp_p_i = 6'd0; ch_qp_q_i = 6'd0; ch_tag_i = '0;
    beta_rdy_i = 1'b1;

    // Reset state
    step();
    step();
    #1;
    check("rst_vld", beta_vld_o, 0);
    check("rst_lu_ack", lu_ack_o, 0);
    check("rst_ch_ack", ch_ack_o, 0);
    check("rst_addr", rom_addr_o, 0);
    check("rst_beta", beta_o, 0);
    check("rst_src", beta_src_o, 0);
    check("rst_tag", beta_tag_o, 0);
    lu_req_i = 1'b0;
    step();
    rst = 1'b0;

    // Both request every cycle: alternating grants starting with luma
    for (int i = 0; i < 8; i++) begin
      step();
      lu_req_i = (i < 6); lu_qp_p_i = 6'd28; lu_qp_q_i = 6'd29; lu_tag_i = 4'd3;
      ch_req_i = (i < 6); ch_qp_p_i = 6'd28; ch_qp_q_i = 6'd29; ch_tag_i = 4'd12;
      #1;
      if (i < 6) begin
`ifdef DB_BETA_LUMA_PRIO_EN
        exp_l = 1'b1;
`else
        exp_l = (i % 2 == 0);
`endif
        check($sformatf("rr_lu_ack%0d", i), lu_ack_o, exp_l);
        check($sformatf("rr_ch_ack%0d", i), ch_ack_o, !exp_l);
      end
      if (i >= 2) begin
`ifdef DB_BETA_LUMA_PRIO_EN
        exp_src = 1'b0;
`else
        exp_src = ((i - 2) % 2 == 1);
`endif
        check($sformatf("rr_vld%0d", i), beta_vld_o, 1);
        check($sformatf("rr_src%0d", i), beta_src_o, exp_src);
        check($sformatf("rr_tag%0d", i), beta_tag_o, exp_src ? 12 : 3);
        check($sformatf("rr_beta%0d", i), beta_o, 7);
      end
    end
    lu_req_i = 1'b0;
    ch_req_i = 1'b0;

    // Isolated requests: basic value and clipping corners
    single(1'b0, 6'd28, 6'd29,  5'sd0,   4'd5,  6'd29, 5'd7,  "t1_lu");
    single(1'b0, 6'd45, 6'd45,  5'sd12,  4'd6,  6'd51, 5'd18, "t2_hiclip");
    single(1'b1, 6'd20, 6'd20, -5'sd12,  4'd9,  6'd8,  5'd0,  "t2_ch");
    single(1'b0, 6'd28, 6'd28, -5'sd12,  4'd2,  6'd16, 5'd2,  "t2_neg");
    single(1'b1, 6'd2,  6'd3,  -5'sd12,  4'd4,  6'd0,  5'd0,  "t2_loclip");
    single(1'b0, 6'd63, 6'd63,  5'sd0,   4'd10, 6'd51, 5'd18, "t5_qpclamp");
    single(1'b1, 6'd0,  6'd0,   5'sd12,  4'd11, 6'd12, 5'd0,  "t5_zero");
    single(1'b0, 6'd63, 6'd10,  5'sd0,   4'd1,  6'd31, 5'd8,  "t5_oneclamp");

    // Backpressure: 4 luma requests, consumer stalls 3 cycles with both stages full
    sent = 0;
    got  = 0;
    offset_b_i = 5'sd0;
    for (int i = 0; i < 10; i++) begin
      step();
      beta_rdy_i = !(i >= 3 && i <= 5);
      lu_req_i   = (sent < 4);
      lu_tag_i   = 4'(sent);
      lu_qp_p_i  = 6'(30 + 2 * sent);
      lu_qp_q_i  = 6'(30 + 2 * sent);
      #1;
      check($sformatf("bp_ack%0d", i), lu_ack_o, stall_ack[i]);
      check($sformatf("bp_chack%0d", i), ch_ack_o, 0);
      if (lu_ack_o) sent++;
      if (i >= 3 && i <= 5) begin
        check($sformatf("bp_hold_vld%0d", i), beta_vld_o, 1);
        check($sformatf("bp_hold_tag%0d", i), beta_tag_o, 1);
        check($sformatf("bp_hold_beta%0d", i), beta_o, 9);
        check($sformatf("bp_hold_addr%0d", i), rom_addr_o, 34);
      end
      if (beta_vld_o && beta_rdy_i) begin
        check($sformatf("bp_tag_out%0d", got), beta_tag_o, got);
        check($sformatf("bp_beta_out%0d", got), beta_o, 8 + got);
        got++;
      end
    end
    check("bp_sent", sent, 4);
    check("bp_got", got, 4);
    check("bp_drained", beta_vld_o, 0);
    lu_req_i = 1'b0;
    beta_rdy_i = 1'b1;

    // Reset with two entries in flight, last grant was luma
    step();
    lu_req_i = 1'b1; lu_qp_p_i = 6'd28; lu_qp_q_i = 6'd29; lu_tag_i = 4'd7;
    #1;
    check("r6_ack0", lu_ack_o, 1);
    step();
    lu_tag_i = 4'd8;
    #1;
    check("r6_ack1", lu_ack_o, 1);
    step();
    rst = 1'b1;
    ch_req_i = 1'b1; ch_qp_p_i = 6'd20; ch_qp_q_i = 6'd20; ch_tag_i = 4'd13;
    #1;
    check("r6_rst_lu_ack", lu_ack_o, 0);
    check("r6_rst_ch_ack", ch_ack_o, 0);
    step();
    rst = 1'b0;
    #1;
    check("r6_vld", beta_vld_o, 0);
    check("r6_addr", rom_addr_o, 0);
    check("r6_beta", beta_o, 0);
    check("r6_tag", beta_tag_o, 0);
    check("r6_tie_lu", lu_ack_o, 1);
    check("r6_tie_ch", ch_ack_o, 0);
    step();
    lu_req_i = 1'b0;
    ch_req_i = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
